// File: rtl/ctmm_excl_monitor_array.sv
// Exclusive-access (LOADX/SAVEX) reservation monitor: one granule reservation per thread,
// snoop/timeout/flush clearing, registered SAVEX pass/fail response and a saturating clear count.
module ctmm_excl_monitor_array #(
   parameter int unsigned NUM_THREADS  = 16,
   parameter int unsigned TID_W        = $clog2(NUM_THREADS),
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned GRANULE_LOG2 = 5,
   parameter int unsigned NUM_SNOOP    = 2,
   parameter int unsigned TIMEOUT      = 1024,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          arm_valid,
   input  logic [TID_W-1:0]              arm_tid,
   input  logic [ADDR_W-1:0]             arm_addr,
   input  logic                          chk_valid,
   input  logic [TID_W-1:0]              chk_tid,
   input  logic [ADDR_W-1:0]             chk_addr,
   output logic                          chk_resp_valid,
   output logic                          chk_pass,
   input  logic [NUM_SNOOP-1:0]          snp_valid,
   input  logic [NUM_SNOOP*TID_W-1:0]    snp_tid,
   input  logic [NUM_SNOOP*ADDR_W-1:0]   snp_addr,
   input  logic                          clr_all,
   input  logic                          clr_tid_valid,
   input  logic [TID_W-1:0]              clr_tid,
   output logic [NUM_THREADS-1:0]        mon_active,
   output logic [CNT_W-1:0]              clear_count
);

   localparam int unsigned GW    = ADDR_W - GRANULE_LOG2;
   localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned SUM_W = $clog2(NUM_THREADS + 1);
   localparam int unsigned ACC_W = CNT_W + SUM_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } res_state_t;

   res_state_t        state_q [NUM_THREADS];
   res_state_t        state_d [NUM_THREADS];
   logic [GW-1:0]     tag_q   [NUM_THREADS];
   logic [GW-1:0]     tag_d   [NUM_THREADS];
   logic [TMR_W-1:0]  timer_q [NUM_THREADS];
   logic [TMR_W-1:0]  timer_d [NUM_THREADS];

   logic [GW-1:0]          arm_gran;
   logic [GW-1:0]          chk_gran;
   logic [NUM_THREADS-1:0] snp_old_hit;
   logic [NUM_THREADS-1:0] snp_new_hit;
   logic [NUM_THREADS-1:0] kill;
   logic [SUM_W-1:0]       kill_sum;
   logic [ACC_W-1:0]       cnt_acc;
   logic [CNT_W-1:0]       cnt_d;
   logic                   pass_c;

   assign arm_gran = arm_addr[ADDR_W-1:GRANULE_LOG2];
   assign chk_gran = chk_addr[ADDR_W-1:GRANULE_LOG2];

   // Foreign snoop hits: against the start-of-cycle tag and against a same-cycle arm tag.
   always_comb begin
      snp_old_hit = '0;
      snp_new_hit = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         for (int i = 0; i < NUM_SNOOP; i++) begin
            if (snp_valid[i] && (snp_tid[i*TID_W +: TID_W] != TID_W'(t))) begin
               if ((state_q[t] == ACTIVE) &&
                   (snp_addr[i*ADDR_W+GRANULE_LOG2 +: GW] == tag_q[t]))
                  snp_old_hit[t] = 1'b1;
               if (snp_addr[i*ADDR_W+GRANULE_LOG2 +: GW] == arm_gran)
                  snp_new_hit[t] = 1'b1;
            end
         end
      end
   end

   // Next reservation state, kill vector and check outcome.
   always_comb begin
      pass_c   = (state_q[chk_tid] == ACTIVE) && (tag_q[chk_tid] == chk_gran) &&
                 !snp_old_hit[chk_tid];
      kill     = '0;
      kill_sum = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         logic act, own_chk, arm_hit, tmo;
         act     = (state_q[t] == ACTIVE);
         own_chk = chk_valid && (chk_tid == TID_W'(t));
         arm_hit = arm_valid && (arm_tid == TID_W'(t));
         tmo     = (TIMEOUT > 0) && act && (timer_q[t] == TMR_W'(1));

         state_d[t] = state_q[t];
         tag_d[t]   = tag_q[t];
         timer_d[t] = timer_q[t];

         if (arm_hit) begin
            // A fresh arm replaces the old reservation; only a foreign snoop on the new granule kills it.
            kill[t]    = snp_new_hit[t];
            state_d[t] = snp_new_hit[t] ? IDLE : ACTIVE;
            tag_d[t]   = arm_gran;
            timer_d[t] = snp_new_hit[t] ? TMR_W'(0) : TMR_W'(TIMEOUT);
         end else begin
            kill[t] = act && ((chk_valid && pass_c && !own_chk && (tag_q[t] == chk_gran)) ||
                              (arm_valid && (tag_q[t] == arm_gran)) ||
                              snp_old_hit[t] || tmo);
            if (kill[t] || own_chk) begin
               state_d[t] = IDLE;
               timer_d[t] = '0;
            end else if (act && (TIMEOUT > 0)) begin
               timer_d[t] = timer_q[t] - TMR_W'(1);
            end
         end

         if (clr_all || (clr_tid_valid && (clr_tid == TID_W'(t)))) begin
            state_d[t] = IDLE;
            timer_d[t] = '0;
         end
         kill_sum = kill_sum + SUM_W'(kill[t]);
      end

      cnt_acc = ACC_W'(clear_count) + ACC_W'(kill_sum);
      cnt_d   = (cnt_acc > ACC_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(cnt_acc);
   end

   // Reservation, response and statistic registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            state_q[t] <= IDLE;
            tag_q[t]   <= '0;
            timer_q[t] <= '0;
         end
         chk_resp_valid <= 1'b0;
         chk_pass       <= 1'b0;
         clear_count    <= '0;
      end else begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            state_q[t] <= state_d[t];
            tag_q[t]   <= tag_d[t];
            timer_q[t] <= timer_d[t];
         end
         chk_resp_valid <= chk_valid;
         if (chk_valid)
            chk_pass <= pass_c;
         clear_count <= cnt_d;
      end
   end

   always_comb begin
      for (int t = 0; t < NUM_THREADS; t++)
         mon_active[t] = (state_q[t] == ACTIVE);
   end

   // Sub-granule address bits carry no meaning for reservations.
   if (GRANULE_LOG2 > 0) begin : g_low_bits
      logic unused_low;
      always_comb begin
         unused_low = (^arm_addr[GRANULE_LOG2-1:0]) ^ (^chk_addr[GRANULE_LOG2-1:0]);
         for (int i = 0; i < NUM_SNOOP; i++)
            unused_low = unused_low ^ (^snp_addr[i*ADDR_W +: GRANULE_LOG2]);
      end
   end

endmodule

// File: doc/ctmm_excl_monitor_array.md
Name: ctmm_excl_monitor_array

Overview:
- Parametrised, stand-alone exclusive-access monitor for LOADX/SAVEX on capability namespace entries.
- Holds one reservation per hardware thread. Arms on LOADX and evaluates SAVEX with a registered pass/fail response.
- Snoops NUM_SNOOP external store/LOADX ports. Adds granule matching, reservation timeout, bulk/per-thread clear and a clear statistic.
- Sits between the CTMM LOADX/SAVEX sequencer and the coherence/snoop fabric.

Parameters:
- NUM_THREADS, 16: number of per-thread reservations (power of 2, 2..64).
- TID_W, $clog2(NUM_THREADS): thread-id width (derived).
- ADDR_W, 32: namespace byte address width.
- GRANULE_LOG2, 5: reservation granule size is 2**GRANULE_LOG2 bytes (32 = one capability entry).
- NUM_SNOOP, 2: number of external snoop ports.
- TIMEOUT, 1024: cycles before an armed reservation self-clears. 0 disables the timeout.
- CNT_W, 16: width of the saturating clear counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- arm_valid  in  1  LOADX completed; arm a reservation.
- arm_tid  in  TID_W  arming thread.
- arm_addr  in  ADDR_W  entry address.
- chk_valid  in  1  SAVEX check request.
- chk_tid  in  TID_W  checking thread.
- chk_addr  in  ADDR_W  SAVEX target address.
- chk_resp_valid  out  1  response strobe, one cycle after chk_valid.
- chk_pass  out  1  1 = store may proceed (DR=0); 0 = fail (DR=1).
- snp_valid  in  NUM_SNOOP  per-port external store or LOADX.
- snp_tid  in  NUM_SNOOP*TID_W  originating thread per port (port i at bits [i*TID_W +: TID_W]).
- snp_addr  in  NUM_SNOOP*ADDR_W  accessed address per port.
- clr_all  in  1  context-switch flush of all reservations.
- clr_tid_valid  in  1  clear one thread's reservation.
- clr_tid  in  TID_W  thread to clear.
- mon_active  out  NUM_THREADS  bit t = thread t reservation armed.
- clear_count  out  CNT_W  saturating count of reservations lost to snoop or timeout.

Behaviour:
- Reset is synchronous (rst high at a clk edge) and leaves:
  - every reservation IDLE, addr 0, timer 0;
  - mon_active=0, chk_resp_valid=0, chk_pass=0, clear_count=0.
  - rst asserted mid-operation discards any pending response; no chk_resp_valid follows.
- Granule match: a[ADDR_W-1:GRANULE_LOG2] == b[ADDR_W-1:GRANULE_LOG2]. Low bits are ignored.
- Per-thread state is IDLE or ACTIVE plus a granule tag.
  - IDLE→ACTIVE: on arm.
  - ACTIVE→IDLE: on check (own thread), foreign conflict, timeout, clr_all or clr_tid.
- Per-cycle evaluation order, all from start-of-cycle state, result registered at the edge:
  1. Check. pass = res[chk_tid] ACTIVE && granule(chk_addr) matches, and no same-cycle foreign kill of that reservation (step 3).
     - res[chk_tid] goes IDLE regardless of outcome.
     - A passing check also kills every other thread's ACTIVE reservation on that granule (the store happens).
  2. Arm. res[arm_tid] := ACTIVE, tag=granule(arm_addr), timer := TIMEOUT. This overrides step 1's clear of the same tid.
     - Every other thread's reservation on that granule is killed.
  3. Snoop. For each port i with snp_valid[i], every ACTIVE res[t] with t != snp_tid[i] and a matching granule is killed.
     - A snoop kill overrides a same-cycle arm by a different thread (res ends IDLE).
     - A snoop with snp_tid == t never kills t.
  4. Timeout. For TIMEOUT>0, an ACTIVE timer decrements each cycle. On the cycle it is 1 it becomes 0 and the reservation goes IDLE (kill), unless re-armed in that cycle (the arm wins).
  5. clr_all / clr_tid_valid. Forces IDLE and overrides everything above, including a same-cycle arm. They do not count as kills. A check in the same cycle still evaluates pass from start-of-cycle state.
- chk_resp_valid is a one-cycle pulse exactly 1 cycle after chk_valid. chk_pass is held until the next response. Back-to-back chk_valid is accepted every cycle (fully pipelined, no backpressure).
- clear_count increments by the number of reservations killed in steps 1–4 that cycle (popcount). It saturates at 2**CNT_W-1 and never wraps.
  - Own-thread check clears, clr_all and clr_tid are excluded.
- mon_active is registered and reflects post-update state.
- Out-of-range tids cannot occur: the widths are exact.

Test Plan:
- Basic pass: arm tid3 @0x1000; 5 cycles later chk tid3 @0x1008 -> next cycle chk_resp_valid=1, chk_pass=1; mon_active[3]=0.
- Foreign snoop: arm tid1 @0x2000; snp port1 tid4 @0x201F -> mon_active[1]=0, clear_count=1; chk tid1 @0x2000 -> chk_pass=0.
- Same-cycle snoop vs check: res tid2 @0x40; chk tid2 @0x40 and snp port0 tid5 @0x40 in one cycle -> chk_pass=0, clear_count=1.
- Own snoop and granule miss: arm tid0 @0x100; snp tid0 @0x100 and snp tid7 @0x120 -> reservation survives; chk tid0 -> chk_pass=1.
- Timeout: TIMEOUT=4; arm tid6 -> mon_active[6] drops exactly 4 cycles after arm, clear_count=1. Re-arm on the expiry cycle -> stays active.
- Flush/reset: arm tids 0..15 then clr_all -> mon_active=0, clear_count unchanged. Assert rst with chk_valid high -> no chk_resp_valid next cycle, all outputs 0.
